// File: rtl/scan_moves_pkg.sv
// Move encoding, FSM state type and the step -> move-list table used while
// scanning the cube faces in ULFRBD order.
package scan_moves_pkg;

  localparam int LIST_LEN = 12;
  localparam int FACE_W   = 3;
  localparam int TURN_W   = 2;
  localparam int MOVE_W   = FACE_W + TURN_W;
  localparam int STEP_W   = 6;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = STEP_W + IDX_W;

  localparam logic [FACE_W-1:0] FACE_U = 3'd0;
  localparam logic [FACE_W-1:0] FACE_L = 3'd1;
  localparam logic [FACE_W-1:0] FACE_F = 3'd2;
  localparam logic [FACE_W-1:0] FACE_R = 3'd3;
  localparam logic [FACE_W-1:0] FACE_B = 3'd4;
  localparam logic [FACE_W-1:0] FACE_D = 3'd5;

  localparam logic [TURN_W-1:0] TURN_END  = 2'b00;
  localparam logic [TURN_W-1:0] TURN_CW   = 2'b01;
  localparam logic [TURN_W-1:0] TURN_HALF = 2'b10;
  localparam logic [TURN_W-1:0] TURN_CCW  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_ISSUE, S_WAIT_MOTOR, S_SETTLE, S_DONE
  } seq_state_t;

  function automatic logic [MOVE_W-1:0] mv(input logic [FACE_W-1:0] f,
                                           input logic [TURN_W-1:0] t);
    return {f, t};
  endfunction

  // Address is {step, move_idx}; anything not listed reads as the terminator,
  // so unlisted steps are empty lists.
  function automatic logic [MOVE_W-1:0] move_lut(input logic [ADDR_W-1:0] addr);
    logic [MOVE_W-1:0] m;
    m = '0;
    case (addr)
      {6'd8,  4'd0}: m = mv(FACE_L, TURN_CW);
      {6'd16, 4'd0}: m = mv(FACE_F, TURN_CCW);
      {6'd24, 4'd0}: m = mv(FACE_U, TURN_CW);
      {6'd28, 4'd0}: m = mv(FACE_F, TURN_CW);
      {6'd28, 4'd1}: m = mv(FACE_B, TURN_CCW);
      {6'd32, 4'd0}: m = mv(FACE_R, TURN_HALF);
      {6'd40, 4'd0}: m = mv(FACE_D, TURN_CW);
      {6'd40, 4'd1}: m = mv(FACE_U, TURN_CCW);
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/setup_move_rom.sv
// Registered lookup of the scan move table; data appears one cycle after the address.
module setup_move_rom
  import scan_moves_pkg::*;
(
  input  logic              clock,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [MOVE_W-1:0] o_data
);

  logic [MOVE_W-1:0] r_data;

  always_ff @(posedge clock) r_data <= move_lut(i_addr);

  assign o_data = r_data;

endmodule

// File: rtl/scan_move_sequencer.sv
// Issues the move list for a scan step to the motor driver one move at a time,
// then waits for the cube to settle before flagging the colour sensor stable.
module scan_move_sequencer
  import scan_moves_pkg::*;
#(
  parameter int MAX_MOVES      = 12,
  parameter int SETTLE_CYCLES  = 5000000,
  parameter int TIMEOUT_CYCLES = 130000000,
  parameter int CNT_W          = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_step,
  output logic              o_move_valid,
  output logic [MOVE_W-1:0] o_move,
  input  logic              i_move_ready,
  input  logic              i_motor_done,
  output logic              o_color_sensor_stable,
  output logic              o_busy,
  output logic              o_fault,
  output logic              o_overrun
);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX      = IDX_W'(MAX_MOVES);

  seq_state_t        r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic [IDX_W-1:0]  r_move_idx;
  logic [MOVE_W-1:0] r_move;
  logic              r_move_valid, r_busy, r_stable, r_fault, r_overrun;
  logic [CNT_W-1:0]  r_cnt;
  logic [MOVE_W-1:0] w_rom_data;
  logic              w_accept_start, w_load_move, w_move_acc, w_done_move;
  logic              w_timeout, w_finish;

  setup_move_rom u_rom (
    .clock  (clock),
    .i_addr ({r_step, r_move_idx}),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept_start = 1'b0;
    w_load_move    = 1'b0;
    w_move_acc     = 1'b0;
    w_done_move    = 1'b0;
    w_timeout      = 1'b0;
    w_finish       = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_start && !r_fault) begin
          w_accept_start = 1'b1;
          w_state_nxt    = S_FETCH;
        end
      S_FETCH: w_state_nxt = S_CHECK;
      S_CHECK:
        if (w_rom_data[TURN_W-1:0] == TURN_END || r_move_idx == IDX_MAX)
          w_state_nxt = (r_move_idx == '0) ? S_DONE : S_SETTLE;
        else begin
          w_load_move = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      S_ISSUE:
        if (i_move_ready) begin
          w_move_acc  = 1'b1;
          w_state_nxt = S_WAIT_MOTOR;
        end
      S_WAIT_MOTOR:
        if (i_motor_done) begin
          w_done_move = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      // The counter restarts at the final motor_done, so fetch/check time
      // counts toward the settle interval.
      S_SETTLE:
        if (r_cnt >= SETTLE_LAST) w_state_nxt = S_DONE;
      S_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_step       <= '0;
      r_move_idx   <= '0;
      r_move       <= '0;
      r_move_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_stable     <= 1'b0;
      r_fault      <= 1'b0;
      r_overrun    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_accept_start) begin
        r_step     <= i_step;
        r_move_idx <= '0;
        r_stable   <= 1'b0;
        r_busy     <= 1'b1;
      end
      if (i_start && r_busy) r_overrun <= 1'b1;
      if (w_load_move) begin
        r_move       <= w_rom_data;
        r_move_valid <= 1'b1;
      end
      if (w_move_acc)  r_move_valid <= 1'b0;
      if (w_done_move) r_move_idx   <= r_move_idx + IDX_W'(1);
      if (w_timeout) begin
        r_fault <= 1'b1;
        r_busy  <= 1'b0;
      end
      if (w_finish) begin
        r_stable <= 1'b1;
        r_busy   <= 1'b0;
      end
      if (w_move_acc || w_done_move) r_cnt <= '0;
      else if (r_state != S_IDLE)    r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Masked by start so the requester never sees last step's stable level
  // in the cycle it asks for the next step.
  assign o_color_sensor_stable = r_stable & ~i_start;
  assign o_move_valid          = r_move_valid;
  assign o_move                = r_move;
  assign o_busy                = r_busy;
  assign o_fault               = r_fault;
  assign o_overrun             = r_overrun;

endmodule

// File: tb/tb_scan_move_sequencer.sv
// Directed bench for scan_move_sequencer with shortened settle/timeout intervals.
module tb_scan_move_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_start, i_move_ready, i_motor_done;
  logic [5:0] i_step;
  logic       o_move_valid, o_color_sensor_stable, o_busy, o_fault, o_overrun;
  logic [4:0] o_move;

  int total = 0;
  int bad   = 0;

  scan_move_sequencer #(.SETTLE_CYCLES(8), .TIMEOUT_CYCLES(20)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .i_start               (i_start),
    .i_step                (i_step),
    .o_move_valid          (o_move_valid),
    .o_move                (o_move),
    .i_move_ready          (i_move_ready),
    .i_motor_done          (i_motor_done),
    .o_color_sensor_stable (o_color_sensor_stable),
    .o_busy                (o_busy),
    .o_fault               (o_fault),
    .o_overrun             (o_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] step;
    int         rdy_dly;
    int         done_dly;
    int         n;
    logic [4:0] m0;
    logic [4:0] m1;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one start and services the handshake; slot 0 is the start cycle,
  // lat is the first slot with stable high.
  task automatic run_seq(input logic [5:0] s, input int rdy_dly, input int done_dly,
                         output int n, output logic [4:0] m0, output logic [4:0] m1,
                         output int lat, output bit ok);
    int waitc, done_at;
    bit armed, vld, stb;
    logic [4:0] held, mv_now;
    n = 0; m0 = '0; m1 = '0; lat = -1; ok = 1'b1;
    armed = 1'b0; done_at = -1; waitc = 0; held = '0;
    i_step = s; i_start = 1'b1; i_move_ready = 1'b0; i_motor_done = 1'b0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      tick();
      vld = o_move_valid; stb = o_color_sensor_stable; mv_now = o_move;
      i_start = 1'b0; i_move_ready = 1'b0; i_motor_done = 1'b0;
      if (k == done_at) i_motor_done = 1'b1;
      if (stb) lat = k;
      else if (vld) begin
        if (done_at >= k) ok = 1'b0;
        if (!armed) begin armed = 1'b1; waitc = rdy_dly; held = mv_now; end
        if (mv_now !== held) ok = 1'b0;
        if (waitc == 0) begin
          i_move_ready = 1'b1;
          armed = 1'b0;
          if (n == 0) m0 = mv_now; else if (n == 1) m1 = mv_now;
          n++;
          done_at = k + done_dly;
        end else waitc--;
      end
    end
  endtask

  initial begin
    int n, lat, acc;
    logic [4:0] m0, m1;
    bit ok;

    vecs[0] = '{6'd24, 0, 10, 1, 5'b000_01, 5'b0, 23};
    vecs[1] = '{6'd28, 3, 10, 2, 5'b010_01, 5'b100_11, 42};
    vecs[2] = '{6'd24, 2, 1,  1, 5'b000_01, 5'b0, 16};
    vecs[3] = '{6'd8,  0, 4,  1, 5'b001_01, 5'b0, 17};
    vecs[4] = '{6'd48, 0, 0,  0, 5'b0, 5'b0, 4};

    reset = 1'b1; i_start = 1'b0; i_step = '0; i_move_ready = 1'b0; i_motor_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_valid",   o_move_valid, 0);
    chk("rst_move",    o_move, 0);
    chk("rst_busy",    o_busy, 0);
    chk("rst_stable",  o_color_sensor_stable, 0);
    chk("rst_fault",   o_fault, 0);
    chk("rst_overrun", o_overrun, 0);

    // Reset while a move is being presented
    i_step = 6'd24; i_start = 1'b1;
    tick(); i_start = 1'b0;
    tick(); tick();
    chk("issue_valid", o_move_valid, 1);
    chk("issue_move",  o_move, 5'b000_01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid",  o_move_valid, 0);
    chk("midrst_busy",   o_busy, 0);
    chk("midrst_stable", o_color_sensor_stable, 0);
    chk("midrst_fault",  o_fault, 0);
    ok = 1'b1;
    repeat (6) begin tick(); if (o_move_valid || o_busy) ok = 1'b0; end
    chk("midrst_quiet", ok, 1);

    foreach (vecs[i]) begin
      run_seq(vecs[i].step, vecs[i].rdy_dly, vecs[i].done_dly, n, m0, m1, lat, ok);
      chk($sformatf("v%0d_nmoves", i), n, vecs[i].n);
      if (vecs[i].n >= 1) chk($sformatf("v%0d_move0", i), m0, vecs[i].m0);
      if (vecs[i].n >= 2) chk($sformatf("v%0d_move1", i), m1, vecs[i].m1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_hold_order", i), ok, 1);
      chk($sformatf("v%0d_busy", i), o_busy, 0);
    end

    // Stable held, then masked in the cycle the next start is visible
    tick();
    chk("stable_held", o_color_sensor_stable, 1);
    i_step = 6'd48; i_start = 1'b1;
    #1;
    chk("stable_masked", o_color_sensor_stable, 0);
    run_seq(6'd48, 0, 0, n, m0, m1, lat, ok);
    chk("empty2_latency", lat, 4);
    chk("empty2_nmoves", n, 0);

    // Start pulsed during WAIT_MOTOR
    i_step = 6'd24; i_start = 1'b1; i_move_ready = 1'b1;
    acc = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (o_move_valid) acc++;
      if (k == 4) chk("ovr_before", o_overrun, 0);
      if (k == 6) begin
        chk("ovr_set",  o_overrun, 1);
        chk("ovr_busy", o_busy, 1);
      end
      i_start      = (k == 5);
      i_motor_done = (k == 13);
    end
    i_move_ready = 1'b0;
    chk("ovr_moves",  acc, 1);
    chk("ovr_stable", o_color_sensor_stable, 1);
    chk("ovr_sticky", o_overrun, 1);

    // Motor never completes: accept at end of slot 3, counter hits 19 in slot 23
    i_step = 6'd24; i_start = 1'b1; i_move_ready = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      i_start = 1'b0;
      if (k == 23) chk("to_fault_early", o_fault, 0);
      if (k == 24) begin
        chk("to_fault",  o_fault, 1);
        chk("to_busy",   o_busy, 0);
        chk("to_stable", o_color_sensor_stable, 0);
      end
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      if (o_busy || o_move_valid || o_color_sensor_stable) ok = 1'b0;
      tick();
    end
    chk("to_start_ignored", ok, 1);
    chk("to_fault_sticky", o_fault, 1);
    i_move_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("to_fault_cleared",   o_fault, 0);
    chk("to_overrun_cleared", o_overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
